aes_shiftrows_enc_serial: RTL and testbench

Byte-serial forward ShiftRows stage for the encryption datapath. Accepts an AES state one byte per cycle in column-major order and emits the same state after forward ShiftRows, also one byte per cycle. Two internal 128-bit block buffers in ping-pong give sustained one-byte-per-cycle throughput under no backpressure. The block sits between the byte-serial SubBytes stage and MixColumns, mirroring the decrypt path's inverse ShiftRows.

---
 rtl/aes_shiftrows_enc_serial_pkg.sv | 16 +
 rtl/aes_shiftrows_enc_serial_pingpong.sv | 36 +++
 rtl/aes_shiftrows_enc_serial.sv | 65 ++++++
 tb/tb_aes_shiftrows_enc_serial.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/aes_shiftrows_enc_serial_pkg.sv
// aes_shiftrows_enc_serial_pkg: shared AES block constants and ShiftRows byte-index helpers.
// Byte k of a 128-bit state lives at bits [127-8k -: 8]; k = 4*column + row.
package aes_shiftrows_enc_serial_pkg;
  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BYTE_W = 8;
  function automatic logic [6:0] byte_msb(input logic [3:0] k);
    return 7'd127 - {k, 3'b000};
  endfunction
  // Source index for output byte k: same row, column (c + r) mod 4.
  function automatic logic [3:0] shiftrows_fwd_idx(input logic [3:0] k);
    return {k[3:2] + k[1:0], k[1:0]};
  endfunction
  function automatic logic [3:0] shiftrows_inv_idx(input logic [3:0] k);
    return {k[3:2] - k[1:0], k[1:0]};
  endfunction
endpackage

// File: rtl/aes_shiftrows_enc_serial_pingpong.sv
// aes_block_pingpong: two 128-bit block buffers with full flags.
// Ports: byte write (wr_en_i/wr_sel_i/wr_idx_i/wr_data_i), wr_done_i marks buffer full,
// byte read (rd_sel_i/rd_idx_i -> rd_data_o), rd_done_i marks buffer empty, full_o flags.
module aes_block_pingpong
  import aes_shiftrows_enc_serial_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic       wr_sel_i,
  input  logic [3:0] wr_idx_i,
  input  logic [7:0] wr_data_i,
  input  logic       wr_done_i,
  input  logic       rd_sel_i,
  input  logic [3:0] rd_idx_i,
  input  logic       rd_done_i,
  output logic [1:0] full_o,
  output logic [7:0] rd_data_o
);
  logic [127:0] mem_q [2];
  logic [1:0] full_q, full_d;
  always_comb begin
    full_d = full_q;
    if (wr_done_i) full_d[wr_sel_i] = 1'b1;
    if (rd_done_i) full_d[rd_sel_i] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) full_q <= 2'b00;
    else full_q <= full_d;
  end
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_sel_i][byte_msb(wr_idx_i) -: 8] <= wr_data_i;
  end
  assign full_o = full_q;
  assign rd_data_o = mem_q[rd_sel_i][byte_msb(rd_idx_i) -: 8];
endmodule

// File: rtl/aes_shiftrows_enc_serial.sv
// aes_shiftrows_enc_serial: byte-serial forward ShiftRows with ping-pong block buffering.
// Ports: s_valid/s_ready/s_data column-major input bytes, m_valid/m_ready/m_data shifted
// output bytes, m_last on the 16th output byte, occupancy = number of full buffers.
module aes_shiftrows_enc_serial
  import aes_shiftrows_enc_serial_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic [1:0] occupancy
);
  logic [3:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic wsel_q, wsel_d, rsel_q, rsel_d;
  logic [1:0] full;
  logic wr_fire, rd_fire, wr_done, rd_done;
  assign s_ready = ~full[wsel_q];
  assign m_valid = full[rsel_q];
  assign m_last = m_valid & (&rcnt_q);
  assign occupancy = {1'b0, full[0]} + {1'b0, full[1]};
  always_comb begin
    wr_fire = s_valid & s_ready;
    rd_fire = m_valid & m_ready;
    wr_done = wr_fire & (&wcnt_q);
    rd_done = rd_fire & (&rcnt_q);
    wcnt_d = wcnt_q + {3'b000, wr_fire};
    rcnt_d = rcnt_q + {3'b000, rd_fire};
    wsel_d = wsel_q ^ wr_done;
    rsel_d = rsel_q ^ rd_done;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
    end
  end
  // A write can only target an empty buffer and a read only a full one, so a
  // simultaneous set and clear always land on different buffers.
  aes_block_pingpong u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_fire),
    .wr_sel_i  (wsel_q),
    .wr_idx_i  (wcnt_q),
    .wr_data_i (s_data),
    .wr_done_i (wr_done),
    .rd_sel_i  (rsel_q),
    .rd_idx_i  (shiftrows_fwd_idx(rcnt_q)),
    .rd_done_i (rd_done),
    .full_o    (full),
    .rd_data_o (m_data)
  );
endmodule

// File: tb/tb_aes_shiftrows_enc_serial.sv
// tb_aes_shiftrows_enc_serial: directed and randomised checks of the byte-serial ShiftRows stage.
module tb_aes_shiftrows_enc_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic m_ready = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, m_valid, m_last;
  logic [7:0] m_data;
  logic [1:0] occupancy;

  aes_shiftrows_enc_serial dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  int checks = 0;
  int passed = 0;
  int cnt = 0;
  int widx = 0;
  int ridx = 0;
  logic [7:0] wblk [16];
  logic [7:0] rblk [16];
  logic [7:0] expq [$];
  logic [127:0] origq [$];
  logic [7:0] cap [$];
  logic stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  function automatic int fwd_src(input int k);
    return (k % 4) + 4 * (((k / 4) + (k % 4)) % 4);
  endfunction

  function automatic int inv_src(input int k);
    return (k % 4) + 4 * (((k / 4) + 4 - (k % 4)) % 4);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Called at a negedge: drives inputs for the coming posedge, checks outputs, updates the model.
  task automatic step(input logic sv, input logic [7:0] sd, input logic mr, output logic acc);
    logic rd;
    logic [127:0] v;
    logic [127:0] rec;
    s_valid = sv;
    s_data = sd;
    m_ready = mr;
    chk("status", {s_ready, m_valid, m_last, occupancy},
        {cnt < 2, cnt > 0, (cnt > 0) && (ridx == 15), 2'(cnt)});
    if (stall_prev) chk("stall_hold", {m_valid, m_data}, {1'b1, prev_data});
    stall_prev = (cnt > 0) && !mr;
    prev_data = m_data;
    acc = sv && (cnt < 2);
    rd = (cnt > 0) && mr;
    if (rd) begin
      if (expq.size() == 0) chk("expq_empty", 1, 0);
      else chk("data", m_data, expq.pop_front());
      cap.push_back(m_data);
      rblk[ridx] = m_data;
      ridx++;
      if (ridx == 16) begin
        for (int k = 0; k < 16; k++) rec[127-8*k -: 8] = rblk[inv_src(k)];
        if (origq.size() == 0) chk("origq_empty", 1, 0);
        else chk("roundtrip", rec, origq.pop_front());
        ridx = 0;
        cnt--;
      end
    end
    if (acc) begin
      wblk[widx] = sd;
      widx++;
      if (widx == 16) begin
        for (int k = 0; k < 16; k++) begin
          expq.push_back(wblk[fwd_src(k)]);
          v[127-8*k -: 8] = wblk[k];
        end
        origq.push_back(v);
        widx = 0;
        cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    widx = 0;
    ridx = 0;
    expq.delete();
    origq.delete();
    stall_prev = 1'b0;
    chk("after_reset", {s_ready, m_valid, m_last, occupancy}, 5'b10000);
  endtask

  task automatic drain();
    int b;
    logic a;
    b = 0;
    while (cnt > 0 && b < 200) begin
      step(1'b0, 8'h00, 1'b1, a);
      b++;
    end
    chk("drain_done", cnt, 0);
  endtask

  initial begin
    vec_t tbl [16];
    logic [7:0] exp_l [16];
    logic a;
    int sent, b;
    exp_l = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
              8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    for (int i = 0; i < 16; i++) begin
      tbl[i].din = 8'(i);
      tbl[i].dout = exp_l[i];
    end
    @(negedge clk);
    do_reset();

    cap.delete();
    for (int i = 0; i < 16; i++) step(1'b1, tbl[i].din, 1'b1, a);
    drain();
    chk("tbl_len", cap.size(), 16);
    for (int i = 0; i < 16 && i < cap.size(); i++) chk("tbl_byte", cap[i], tbl[i].dout);

    cap.delete();
    for (int i = 0; i < 32; i++) step(1'b1, 8'(i), 1'b1, a);
    drain();
    chk("b2b_len", cap.size(), 32);
    for (int i = 0; i < 16 && i + 16 < cap.size(); i++)
      chk("b2b_second", cap[i+16], 8'h10 | tbl[i].dout);

    for (int i = 0; i < 48; i++) step(1'b1, 8'(i), 1'b0, a);
    chk("stall_occ", occupancy, 2);
    chk("stall_sready", s_ready, 0);
    chk("stall_mdata", m_data, 8'h00);
    drain();

    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b1, a);
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hA0 + i), 1'b1, a);
    drain();

    for (int i = 0; i < 32; i++) step(1'b1, 8'($urandom), 1'b0, a);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, a);
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b1, a);
    drain();

    sent = 0;
    b = 0;
    while (sent < 1600 && b < 20000) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), a);
      if (a) sent++;
      b++;
    end
    chk("rand_sent", sent, 1600);
    drain();
    chk("rand_leftover", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
